// File: rtl/cu_data_read_command_generator_pkg.sv
// -----------------------------------------------------------------------------
// cu_data_read_command_generator_pkg
// Shared globals for the data-read compute unit: cacheline geometry, address
// masks, read credit budget, CU identifiers and the command generator's state
// and command types. Also provides the cacheline-count helper used in ALIGN.
// -----------------------------------------------------------------------------
package cu_data_read_command_generator_pkg;

  localparam int CACHELINE_SIZE  = 128;
  localparam int CACHELINE_SHIFT = 7;

  localparam logic [63:0] ADDRESS_DATA_READ_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FF80;
  localparam logic [63:0] ADDRESS_DATA_READ_MOD_MASK   = 64'h0000_0000_0000_007F;

  localparam int CREDITS_READ = 32;

  typedef logic [7:0] cu_id_t;
  localparam cu_id_t DATA_READ_CONTROL_ID = 8'h21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } read_cmd_gen_state_t;

  typedef struct packed {
    logic [63:0] address;
    logic [7:0]  size;
    cu_id_t      cu_id;
    logic [31:0] cl_index;
  } read_cmd_t;

  // Number of cachelines touched by a job: (offset + size + 127) >> 7.
  // Evaluated in 40 bits so a 32-bit size plus offset cannot overflow; the
  // result always fits in 32 bits (at most 2^25 + 1).
  function automatic logic [31:0] cl_count(input logic [6:0] offset,
                                           input logic [31:0] size);
    logic [39:0] total;
    total = {33'd0, offset} + {8'd0, size} + 40'd127;
    return total[38:CACHELINE_SHIFT];
  endfunction

endpackage

// File: rtl/cu_data_read_command_generator_if.sv
// -----------------------------------------------------------------------------
// cu_data_read_command_generator_if
// Job, command and response signals of the data-read command generator.
//   job_*  : host job offer (valid/ready, byte address, byte length)
//   cmd_*  : cacheline read command toward the read command buffer
//   rsp_done_in : one read response retired
// modport master : the command generator
// modport slave  : job source / command sink / response source
// -----------------------------------------------------------------------------
interface cu_data_read_command_generator_if;
  import cu_data_read_command_generator_pkg::*;

  logic        job_valid_in;
  logic        job_ready_out;
  logic [63:0] job_address_in;
  logic [31:0] job_size_in;

  logic        cmd_valid_out;
  logic        cmd_ready_in;
  logic [63:0] cmd_address_out;
  logic [7:0]  cmd_size_out;
  cu_id_t      cmd_cu_id_out;
  logic [31:0] cmd_cl_index_out;

  logic        rsp_done_in;

  modport master (
    input  job_valid_in, job_address_in, job_size_in, cmd_ready_in, rsp_done_in,
    output job_ready_out, cmd_valid_out, cmd_address_out, cmd_size_out,
           cmd_cu_id_out, cmd_cl_index_out
  );

  modport slave (
    output job_valid_in, job_address_in, job_size_in, cmd_ready_in, rsp_done_in,
    input  job_ready_out, cmd_valid_out, cmd_address_out, cmd_size_out,
           cmd_cu_id_out, cmd_cl_index_out
  );

endinterface

// File: rtl/cu_data_read_command_generator_credit_counter.sv
// -----------------------------------------------------------------------------
// cu_credit_counter
// In-flight request counter with a fixed budget MAX.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc_in       : one request issued
//   dec_in       : one request retired
//   count_out    : current in-flight count ($clog2(MAX)+1 bits)
//   full_out     : count == MAX
//   error_out    : sticky, a retire arrived while nothing was in flight
// -----------------------------------------------------------------------------
module cu_credit_counter #(
  parameter int MAX = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc_in,
  input  logic                 dec_in,
  output logic [$clog2(MAX):0] count_out,
  output logic                 full_out,
  output logic                 error_out
);

  localparam int              CW        = $clog2(MAX) + 1;
  localparam logic [CW-1:0]   ONE       = CW'(1);
  localparam logic [CW-1:0]   ZERO      = CW'(0);
  localparam logic [CW-1:0]   MAX_COUNT = CW'(MAX);

  logic [CW-1:0] count_q, count_d;
  logic          error_q, error_d;

  // Next count: simultaneous inc and dec cancel; an underflowing dec holds
  // the count and latches the error flag.
  always_comb begin
    count_d = count_q;
    error_d = error_q;
    case ({inc_in, dec_in})
      2'b10: count_d = count_q + ONE;
      2'b01: begin
        if (count_q == ZERO) begin
          error_d = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
      default: count_d = count_q;
    endcase
  end

  // Counter and sticky error registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= ZERO;
      error_q <= 1'b0;
    end else begin
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign count_out = count_q;
  assign full_out  = (count_q == MAX_COUNT);
  assign error_out = error_q;

endmodule

// File: rtl/cu_data_read_command_generator.sv
// -----------------------------------------------------------------------------
// cu_data_read_command_generator
// Splits one host read job (byte address + byte length) into cacheline-aligned
// 128-byte read commands tagged with CU_ID, limits in-flight reads to
// MAX_OUTSTANDING and pulses done_out once all commands are issued and all
// responses have returned.
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   enabled_in      : gate for offering a new command
//   bus (master)    : job offer, command stream, response retire
//   outstanding_out : in-flight read count
//   done_out        : one-cycle completion pulse
//   error_out       : sticky, response retired with nothing in flight
// -----------------------------------------------------------------------------
module cu_data_read_command_generator
  import cu_data_read_command_generator_pkg::*;
#(
  parameter cu_id_t CU_ID           = DATA_READ_CONTROL_ID,
  parameter int     MAX_OUTSTANDING = CREDITS_READ
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enabled_in,
  cu_data_read_command_generator_if.master bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out,
  output logic                             done_out,
  output logic                             error_out
);

  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  read_cmd_gen_state_t state_q, state_d;
  logic [63:0]         job_address_q, job_address_d;
  logic [31:0]         job_size_q, job_size_d;
  logic [63:0]         cmd_address_q, cmd_address_d;
  logic [31:0]         cl_index_q, cl_index_d;
  logic [31:0]         cl_total_q, cl_total_d;
  logic                hold_q, hold_d;

  logic                cmd_valid_s;
  logic                handshake_s;
  logic [OW-1:0]       outstanding_s;
  logic                credit_full_s;
  logic                credit_error_s;
  read_cmd_t           cmd_s;

  cu_credit_counter #(
    .MAX (MAX_OUTSTANDING)
  ) u_credit (
    .clock     (clock),
    .reset     (reset),
    .inc_in    (handshake_s),
    .dec_in    (bus.rsp_done_in),
    .count_out (outstanding_s),
    .full_out  (credit_full_s),
    .error_out (credit_error_s)
  );

  // A command already offered (hold_q) stays offered until accepted, even if
  // enabled_in drops or credits run out; a fresh offer needs both.
  assign cmd_valid_s = (state_q == ST_ISSUE) &&
                       (hold_q || (enabled_in && !credit_full_s));
  assign handshake_s = cmd_valid_s && bus.cmd_ready_in;

  // Next-state and datapath update for the job FSM.
  always_comb begin
    state_d       = state_q;
    job_address_d = job_address_q;
    job_size_d    = job_size_q;
    cmd_address_d = cmd_address_q;
    cl_index_d    = cl_index_q;
    cl_total_d    = cl_total_q;
    hold_d        = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.job_valid_in) begin
          job_address_d = bus.job_address_in;
          job_size_d    = bus.job_size_in;
          state_d       = ST_ALIGN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ALIGN: begin
        cmd_address_d = job_address_q & ADDRESS_DATA_READ_ALIGN_MASK;
        cl_index_d    = 32'd0;
        hold_d        = 1'b0;
        cl_total_d    = cl_count(7'(job_address_q & ADDRESS_DATA_READ_MOD_MASK),
                                 job_size_q);
        if (job_size_q == 32'd0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (handshake_s) begin
          cmd_address_d = cmd_address_q + 64'(CACHELINE_SIZE);
          cl_index_d    = cl_index_q + 32'd1;
          hold_d        = 1'b0;
          if ((cl_index_q + 32'd1) == cl_total_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          hold_d = cmd_valid_s;
        end
      end
      ST_DRAIN: begin
        if (outstanding_s == {OW{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and job datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      job_address_q <= 64'd0;
      job_size_q    <= 32'd0;
      cmd_address_q <= 64'd0;
      cl_index_q    <= 32'd0;
      cl_total_q    <= 32'd0;
      hold_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_address_q <= job_address_d;
      job_size_q    <= job_size_d;
      cmd_address_q <= cmd_address_d;
      cl_index_q    <= cl_index_d;
      cl_total_q    <= cl_total_d;
      hold_q        <= hold_d;
    end
  end

  assign cmd_s = '{address:  cmd_address_q,
                   size:     8'(CACHELINE_SIZE),
                   cu_id:    CU_ID,
                   cl_index: cl_index_q};

  assign bus.job_ready_out    = (state_q == ST_IDLE);
  assign bus.cmd_valid_out    = cmd_valid_s;
  assign bus.cmd_address_out  = cmd_s.address;
  assign bus.cmd_size_out     = cmd_s.size;
  assign bus.cmd_cu_id_out    = cmd_s.cu_id;
  assign bus.cmd_cl_index_out = cmd_s.cl_index;

  assign outstanding_out = outstanding_s;
  assign done_out        = (state_q == ST_DONE);
  assign error_out       = credit_error_s;

endmodule
